// File: rtl/register_file.sv
// Multi-ported register file with per-register pending (scoreboard) bits.
// Provides two combinational read ports, optional write forwarding and a sticky reserve-conflict flag.
module register_file #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             WriteEn,
    input  logic [AW-1:0]    WriteAddr,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [AW-1:0]    ReadAddrA,
    input  logic [AW-1:0]    ReadAddrB,
    output logic [WIDTH-1:0] DataOutA,
    output logic [WIDTH-1:0] DataOutB,
    input  logic             ReserveEn,
    input  logic [AW-1:0]    ReserveAddr,
    output logic             BusyA,
    output logic             BusyB,
    output logic [AW:0]      PendingCount,
    output logic             ReserveConflict
);

    localparam bit LP_ZERO   = (ZERO_REG != 0);
    localparam bit LP_BYPASS = (BYPASS != 0);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pending;
    logic             r_conflict;

    logic             w_wr_ok;
    logic             w_rs_ok;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic             w_conflict_hit;
    logic [DEPTH-1:0] w_pend_d;
    logic [AW:0]      w_count;

    // Index 0 is hardwired when ZERO_REG is set, so it never accepts writes or reserves.
    assign w_wr_ok = WriteEn && !(LP_ZERO && (WriteAddr == '0));
    assign w_rs_ok = ReserveEn && !(LP_ZERO && (ReserveAddr == '0));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[WriteAddr] <= DataIn;
        end
    end

    // Write clears first, reserve sets last, so a same-index reserve wins.
    always_comb begin
        w_pend_d = r_pending;
        if (w_wr_ok) begin
            w_pend_d[WriteAddr] = 1'b0;
        end
        if (w_rs_ok) begin
            w_pend_d[ReserveAddr] = 1'b1;
        end
    end

    assign w_conflict_hit = w_rs_ok && r_pending[ReserveAddr]
                            && !(w_wr_ok && (WriteAddr == ReserveAddr));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_pending  <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_pending <= w_pend_d;
            if (w_conflict_hit) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign w_fwd_a = LP_BYPASS && w_wr_ok && (WriteAddr == ReadAddrA);
    assign w_fwd_b = LP_BYPASS && w_wr_ok && (WriteAddr == ReadAddrB);

    always_comb begin
        DataOutA = r_regs[ReadAddrA];
        DataOutB = r_regs[ReadAddrB];
        BusyA    = r_pending[ReadAddrA];
        BusyB    = r_pending[ReadAddrB];
        if (w_fwd_a) begin
            DataOutA = DataIn;
            BusyA    = 1'b0;
        end
        if (w_fwd_b) begin
            DataOutB = DataIn;
            BusyB    = 1'b0;
        end
        // Reset overrides forwarding as well as stored state.
        if (clear) begin
            DataOutA = '0;
            DataOutB = '0;
            BusyA    = 1'b0;
            BusyB    = 1'b0;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_count = w_count + {{AW{1'b0}}, r_pending[i]};
        end
    end

    assign PendingCount    = clear ? '0 : w_count;
    assign ReserveConflict = r_conflict;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: default, no-bypass and 8x4 instances.
module tb_register_file;

    logic        clock;
    logic        clear;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] din;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        re;
    logic [3:0]  raddr;

    logic [31:0] m_dout_a, m_dout_b, n_dout_a, n_dout_b;
    logic        m_busy_a, m_busy_b, n_busy_a, n_busy_b;
    logic [4:0]  m_cnt, n_cnt;
    logic        m_conf, n_conf;

    logic        s_we;
    logic [1:0]  s_waddr;
    logic [7:0]  s_din;
    logic [1:0]  s_ra;
    logic [1:0]  s_rb;
    logic        s_re;
    logic [1:0]  s_raddr;
    logic [7:0]  s_dout_a, s_dout_b;
    logic        s_busy_a, s_busy_b;
    logic [2:0]  s_cnt;
    logic        s_conf;

    int n_checks = 0;
    int n_errors = 0;

    register_file u_main (
        .clock(clock), .clear(clear), .WriteEn(we), .WriteAddr(waddr), .DataIn(din),
        .ReadAddrA(ra), .ReadAddrB(rb), .DataOutA(m_dout_a), .DataOutB(m_dout_b),
        .ReserveEn(re), .ReserveAddr(raddr), .BusyA(m_busy_a), .BusyB(m_busy_b),
        .PendingCount(m_cnt), .ReserveConflict(m_conf)
    );

    register_file #(.BYPASS(0)) u_nobyp (
        .clock(clock), .clear(clear), .WriteEn(we), .WriteAddr(waddr), .DataIn(din),
        .ReadAddrA(ra), .ReadAddrB(rb), .DataOutA(n_dout_a), .DataOutB(n_dout_b),
        .ReserveEn(re), .ReserveAddr(raddr), .BusyA(n_busy_a), .BusyB(n_busy_b),
        .PendingCount(n_cnt), .ReserveConflict(n_conf)
    );

    register_file #(.WIDTH(8), .DEPTH(4)) u_small (
        .clock(clock), .clear(clear), .WriteEn(s_we), .WriteAddr(s_waddr), .DataIn(s_din),
        .ReadAddrA(s_ra), .ReadAddrB(s_rb), .DataOutA(s_dout_a), .DataOutB(s_dout_b),
        .ReserveEn(s_re), .ReserveAddr(s_raddr), .BusyA(s_busy_a), .BusyB(s_busy_b),
        .PendingCount(s_cnt), .ReserveConflict(s_conf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear = 1'b1;
        we = 1'b0; waddr = '0; din = '0; ra = '0; rb = '0; re = 1'b0; raddr = '0;
        s_we = 1'b0; s_waddr = '0; s_din = '0; s_ra = '0; s_rb = '0; s_re = 1'b0; s_raddr = '0;

        #2;
        check("rst_dout_a", m_dout_a, 0);
        check("rst_busy_a", m_busy_a, 0);
        check("rst_cnt", m_cnt, 0);
        check("rst_conf", m_conf, 0);
        tick();
        clear = 1'b0;
        tick();

        // Basic write then read, then asynchronous clear between edges.
        we = 1'b1; waddr = 4'd3; din = 32'h1;
        tick();
        we = 1'b0; ra = 4'd3;
        #1 check("wr3_rd_a", m_dout_a, 32'h1);
        check("wr3_rd_a_nb", n_dout_a, 32'h1);
        clear = 1'b1;
        #1 check("clr_async_a", m_dout_a, 0);
        clear = 1'b0;
        #1 check("clr_stays_0", m_dout_a, 0);

        // Write attempted while in clear is dropped; forwarding suppressed too.
        we = 1'b1; waddr = 4'd4; din = 32'h44; ra = 4'd4; clear = 1'b1;
        #1 check("clr_no_fwd", m_dout_a, 0);
        tick();
        clear = 1'b0;
        #1 check("post_clr_fwd", m_dout_a, 32'h44);
        check("post_clr_nb_old", n_dout_a, 0);
        tick();
        we = 1'b0;
        #1 check("post_clr_wr", n_dout_a, 32'h44);

        // Register 0 is hardwired.
        we = 1'b1; waddr = 4'd0; din = 32'hDEADBEEF; ra = 4'd0;
        #1 check("r0_no_fwd", m_dout_a, 0);
        tick();
        we = 1'b0;
        #1 check("r0_read", m_dout_a, 0);
        re = 1'b1; raddr = 4'd0;
        tick();
        tick();
        re = 1'b0;
        #1 check("r0_busy", m_busy_a, 0);
        check("r0_cnt", m_cnt, 0);
        check("r0_conf", m_conf, 0);

        // Forwarding on port B with a pending target.
        re = 1'b1; raddr = 4'd5; rb = 4'd5;
        tick();
        re = 1'b0;
        #1 check("r5_busy_b", m_busy_b, 1);
        we = 1'b1; waddr = 4'd5; din = 32'h12;
        #1 check("fwd_dout_b", m_dout_b, 32'h12);
        check("fwd_busy_b", m_busy_b, 0);
        check("nb_dout_b", n_dout_b, 0);
        check("nb_busy_b", n_busy_b, 1);
        tick();
        we = 1'b0;
        #1 check("r5_dout_b", n_dout_b, 32'h12);
        check("r5_cleared", m_busy_b, 0);
        check("r5_cnt", m_cnt, 0);

        // Reserve and write same index on one edge after it is pending: no conflict.
        re = 1'b1; raddr = 4'd6; ra = 4'd6;
        tick();
        we = 1'b1; waddr = 4'd6; din = 32'h66;
        tick();
        re = 1'b0; we = 1'b0;
        #1 check("r6_no_conf", m_conf, 0);
        check("r6_busy", m_busy_a, 1);
        we = 1'b1; waddr = 4'd6; din = 32'h67;
        tick();
        we = 1'b0;

        // Reserve, double-reserve conflict, then release by write.
        re = 1'b1; raddr = 4'd7; ra = 4'd7;
        tick();
        #1 check("r7_busy", m_busy_a, 1);
        check("r7_cnt", m_cnt, 1);
        check("r7_conf0", m_conf, 0);
        tick();
        re = 1'b0;
        #1 check("r7_conf1", m_conf, 1);
        we = 1'b1; waddr = 4'd7; din = 32'h77;
        tick();
        we = 1'b0;
        #1 check("r7_free", m_busy_a, 0);
        check("r7_cnt0", m_cnt, 0);
        check("r7_sticky", m_conf, 1);

        // Same-edge reserve and write to reg 2: data lands, pending stays set.
        re = 1'b1; raddr = 4'd2; we = 1'b1; waddr = 4'd2; din = 32'hA5; ra = 4'd2;
        tick();
        re = 1'b0; we = 1'b0;
        #1 check("r2_data", m_dout_a, 32'hA5);
        check("r2_busy", m_busy_a, 1);
        check("r2_cnt", m_cnt, 1);
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = 4'(i);
            tick();
        end
        re = 1'b0;
        #1 check("all_cnt15", m_cnt, 15);
        clear = 1'b1;
        #1 check("clr_cnt", m_cnt, 0);
        check("clr_conf", m_conf, 0);
        check("clr_busy", m_busy_a, 0);
        tick();
        clear = 1'b0;

        // Narrow instance.
        s_we = 1'b1; s_waddr = 2'd3; s_din = 8'hFF;
        tick();
        s_we = 1'b0; s_ra = 2'd3; s_rb = 2'd3;
        #1 check("s_dout_a", s_dout_a, 8'hFF);
        check("s_dout_b", s_dout_b, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            s_re = 1'b1; s_raddr = 2'(i);
            tick();
        end
        s_re = 1'b0;
        #1 check("s_cnt3", s_cnt, 3);
        check("s_busy_a", s_busy_a, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32: data bits per register.
REQ-002 Parameter DEPTH, default 16: number of registers; power of two, >= 2; AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1: 1 makes register 0 read-as-zero and write-ignored.
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding in the same cycle.
REQ-005 clock  input  1  single clock, rising-edge active.
REQ-006 clear  input  1  reset, asynchronous, active-high.
REQ-007 WriteEn  input  1  write strobe, sampled on rising clock.
REQ-008 WriteAddr  input  AW  write register index.
REQ-009 DataIn  input  WIDTH  write data.
REQ-010 ReadAddrA, ReadAddrB  input  AW  read port indices.
REQ-011 DataOutA, DataOutB  output  WIDTH  read data, combinational from address.
REQ-012 ReserveEn  input  1  mark a register pending (result outstanding).
REQ-013 ReserveAddr  input  AW  index to reserve.
REQ-014 BusyA, BusyB  output  1  pending status of ReadAddrA / ReadAddrB.
REQ-015 PendingCount  output  AW+1  number of pending registers.
REQ-016 ReserveConflict  output  1  sticky flag: reserve issued to an already-pending register.

Function
REQ-017 Write: on rising clock with WriteEn=1, reg[WriteAddr] <= DataIn; WriteEn=0 leaves all registers unchanged.
REQ-018 ZERO_REG=1: writes to index 0 discarded; reads of index 0 return 0; index 0 never pending, never busy, never counted; reserve to index 0 ignored, no conflict.
REQ-019 Read: DataOutX = reg[ReadAddrX] combinationally; both ports independent; A==B addresses allowed.
REQ-020 BYPASS=1: WriteEn=1 and WriteAddr==ReadAddrX (index 0 excluded when ZERO_REG=1) -> DataOutX = DataIn in that cycle; BYPASS=0 -> old contents until the edge.
REQ-021 Pending vector: one bit per register; ReserveEn=1 sets pending[ReserveAddr] at the rising edge.
REQ-022 WriteEn=1 clears pending[WriteAddr] at the rising edge.
REQ-023 Same edge, ReserveEn and WriteEn to the same index: data written and pending ends set (reserve wins).
REQ-024 Same edge, different indices: both actions take effect.
REQ-025 BusyX = pending[ReadAddrX]; with BYPASS=1, BusyX = 0 while WriteEn=1 and WriteAddr==ReadAddrX (value forwarded).
REQ-026 PendingCount = population count of pending vector, registered state only, range 0..DEPTH.
REQ-027 ReserveEn=1 to an index whose pending bit is already 1 and not cleared by a write on the same edge sets ReserveConflict at that edge; stays 1 until clear.
REQ-028 No arithmetic wrap: PendingCount saturates naturally at DEPTH (all bits set); no other counters.

Reset
REQ-029 clear=1 immediately, without a clock edge, sets all registers to 0, all pending bits to 0, ReserveConflict to 0.
REQ-030 During clear=1, writes and reserves ignored; DataOutX=0 except BYPASS=1 forwarding is also suppressed; BusyX=0; PendingCount=0.
REQ-031 clear asserted mid-write cycle: register not updated; first write accepted on first rising edge after clear deasserts.

Verification
REQ-032 Write 32'h00000001 to reg 3, read A=3 next cycle -> DataOutA=32'h00000001; assert clear between edges -> DataOutA=0 before next edge.
REQ-033 ZERO_REG=1: write 32'hDEADBEEF to reg 0 -> DataOutA(addr 0)=0; reserve reg 0 -> BusyA=0, PendingCount=0, ReserveConflict=0.
REQ-034 BYPASS=1: WriteEn=1, WriteAddr=5, DataIn=32'h12, ReadAddrB=5 same cycle -> DataOutB=32'h12, BusyB=0; BYPASS=0 -> old value 0.
REQ-035 Reserve reg 7 -> BusyA(addr 7)=1, PendingCount=1; reserve 7 again -> ReserveConflict=1; write 7 -> BusyA=0, PendingCount=0, ReserveConflict stays 1.
REQ-036 Same edge reserve and write reg 2 with 32'hA5 -> reg2=32'hA5, pending[2]=1; reserve all 15 nonzero regs -> PendingCount=15.
REQ-037 WIDTH=8, DEPTH=4 instance: write 8'hFF to reg 3, read both ports addr 3 -> both 8'hFF; PendingCount width 3.
